jk_excitation_driver: RTL
=========================

// Module: jk_excitation_driver
// PURPOSE
//   Initiator side of the JK flip-flop interface: accepts a WIDTH-bit target state over a
//   valid/ready handshake and drives per-bit J/K excitation into an external bank of JK FFs.
//   Reads the bank's Q back, retries on mismatch and reports done or error.
//   Sits between a test or control sequencer and a jk_ff register bank clocked by the same clk.
// PARAMETERS
//   WIDTH          4   number of JK flip-flops driven (>=1)
//   SETTLE_CYC     1   cycles waited after J/K deassert before Q is compared (>=1)
//   MAX_RETRY      2   re-drive attempts after first mismatch before error (0..15)
//   PREFER_TOGGLE  0   1: use J=K=1 for 0->1 and 1->0 changes; 0: use pure set/reset codes
// PORTS
//   clk            in   1      rising-edge clock shared with the JK bank
//   rst_n          in   1      asynchronous active-low reset
//   tgt_valid      in   1      target word valid
//   tgt_ready      out  1      driver idle, can accept a target
//   tgt_data       in   WIDTH  requested next state of the JK bank
//   q_fb           in   WIDTH  Q outputs of the JK bank, fed back
//   j              out  WIDTH  J inputs to the bank (registered)
//   k              out  WIDTH  K inputs to the bank (registered)
//   done           out  1      one-cycle pulse: bank Q equals target
//   err            out  1      one-cycle pulse: retries exhausted
//   mismatch_mask  out  WIDTH  q_fb ^ target at error; cleared on next accept
//   ok_cnt         out  8      count of successful transactions, wraps 255->0
// BEHAVIOUR
//   Reset (rst_n low, immediate): state=IDLE, j=k=0, done=err=0, mismatch_mask=0, ok_cnt=0,
//     retry count=0. tgt_ready is 1 once in IDLE.
//   States: IDLE -> DRIVE -> WAIT -> CHECK -> (IDLE | DRIVE | IDLE with err).
//   IDLE: tgt_ready=1. If tgt_valid=1 on an edge: latch tgt_data, clear mismatch_mask and the
//     retry count, go to DRIVE. tgt_ready=0 in every other state; tgt_data is then ignored.
//   DRIVE (1 cycle): on the exiting edge, register j/k per bit from (q_fb[i], target[i]):
//     0->0: J=0,K=0   1->1: J=0,K=0
//     0->1: J=1,K=PREFER_TOGGLE   1->0: J=PREFER_TOGGLE,K=1
//     Load the settle counter with SETTLE_CYC and go to WAIT.
//   j/k are nonzero for exactly one clock cycle. The bank samples them on the first edge in WAIT.
//     j/k return to 0 (hold code) on that same edge.
//   WAIT: decrement the counter each edge. Go to CHECK on the edge where it reaches 0.
//   CHECK (1 cycle), comparing q_fb with target on the exiting edge:
//     equal: done=1 for the next cycle, ok_cnt+1, go to IDLE.
//     differ and retry count < MAX_RETRY: retry count+1, go to DRIVE.
//       Excitation is recomputed from the current q_fb.
//     differ and retry count = MAX_RETRY: err=1 for the next cycle, mismatch_mask=q_fb^target, go to IDLE.
//   Latency (SETTLE_CYC=1, no retry): accept on edge E0; done is high in the cycle after E3.
//     tgt_ready returns high in that same cycle.
//   done and err never assert together. Neither asserts outside the cycle following CHECK.
//   Target equal to current Q: j=k=0 in DRIVE, done still issued at normal latency.
//   A new tgt_valid arriving with done is accepted on that cycle's edge (back-to-back, no bubble).
//   Reset mid-transaction: j/k forced to 0 at once, transaction discarded, no done/err.
//   ok_cnt wraps modulo 256. It is not incremented on err.
// TESTING
//   1 Reset, bank Q=0000, send 1010 -> j=1010,k=0000 for one cycle; done in cycle 4; ok_cnt=1.
//   2 PREFER_TOGGLE=1, Q=1100, target 0110 -> j=1010,k=1010 for one cycle; done; Q=0110.
//   3 Bank model with bit0 stuck at 0, target 0001, MAX_RETRY=2 -> three DRIVE pulses, err=1,
//     mismatch_mask=0001, done never asserted.
//   4 Target equals Q (0101) -> j=k=0000 throughout; done at nominal latency.
//   5 rst_n low during WAIT -> j=k=0 immediately, no done/err; next target completes normally.
//   6 tgt_valid held high for 300 transactions -> back-to-back accepts; ok_cnt wraps to 44.

Source files
------------

// File: rtl/jk_excitation_driver_if.sv
// rtl/jk_excitation_driver_if.sv - target-word handshake between sequencer and JK excitation driver
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives J/K excitation into a JK bank, verifies Q, retries or flags error
module jk_excitation_driver #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYC    = 1,
    parameter int MAX_RETRY     = 2,
    parameter int PREFER_TOGGLE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jk_excitation_driver_if.slave  tgt,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [WIDTH-1:0]       j,
    output logic [WIDTH-1:0]       k,
    output logic                   done,
    output logic                   err,
    output logic [WIDTH-1:0]       mismatch_mask,
    output logic [7:0]             ok_cnt
);
    localparam int CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [CW-1:0]    settle;
    logic [3:0]       retry;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;

    // Bits needing 0->1 or 1->0; toggle mode drives the opposite input as well.
    assign set_bits = ~q_fb & target;
    assign clr_bits = q_fb & ~target;
    assign j_next   = set_bits | ((PREFER_TOGGLE != 0) ? clr_bits : '0);
    assign k_next   = clr_bits | ((PREFER_TOGGLE != 0) ? set_bits : '0);

    assign tgt.tgt_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            target        <= '0;
            settle        <= '0;
            retry         <= '0;
            j             <= '0;
            k             <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            mismatch_mask <= '0;
            ok_cnt        <= '0;
        end else begin
            // Excitation and status are single-cycle pulses; hold code is the default.
            j    <= '0;
            k    <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt.tgt_valid) begin
                        target        <= tgt.tgt_data;
                        mismatch_mask <= '0;
                        retry         <= '0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    j      <= j_next;
                    k      <= k_next;
                    settle <= CW'(SETTLE_CYC);
                    state  <= WAIT;
                end
                WAIT: begin
                    settle <= settle - CW'(1);
                    if (settle == CW'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (q_fb == target) begin
                        done   <= 1'b1;
                        ok_cnt <= ok_cnt + 8'd1;
                        state  <= IDLE;
                    end else if (retry != 4'(MAX_RETRY)) begin
                        retry <= retry + 4'd1;
                        state <= DRIVE;
                    end else begin
                        err           <= 1'b1;
                        mismatch_mask <= q_fb ^ target;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
